// File: rtl/seq_mul.sv
//------------------------------------------------------------------------------
// seq_mul : iterative signed shift-add multiplier, DATAWIDTH cycles per product,
//           truncated to the low DATAWIDTH bits. Optional SEQ_MUL_OVF_EN
//           enables the signed overflow flag (otherwise ovf is tied low).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_mul #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] p,
  output logic                 ovf
);

  localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state, state_nx;
  logic                   load, step, finish;

  logic [DATAWIDTH-1:0]   mag_b;
  logic [2*DATAWIDTH-1:0] mcand;
  logic [2*DATAWIDTH-1:0] acc;
  logic [CW-1:0]          cnt;
  logic                   neg;

  logic [DATAWIDTH-1:0]   abs_a, abs_b, acc_lo;

  // Two's-complement magnitude; the most negative value maps to 2^(DW-1) unsigned.
  assign abs_a  = a[DATAWIDTH-1] ? (~a + DATAWIDTH'(1)) : a;
  assign abs_b  = b[DATAWIDTH-1] ? (~b + DATAWIDTH'(1)) : b;
  assign acc_lo = acc[DATAWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    load   = (state == IDLE) && start;
    step   = (state == CALC);
    finish = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_b <= '0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      p     <= '0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        mag_b <= abs_b;
        mcand <= {{DATAWIDTH{1'b0}}, abs_a};
        neg   <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
        acc   <= '0;
        cnt   <= '0;
      end
      if (step) begin
        // mcand tracks mag_a << cnt by shifting once per iteration
        if (mag_b[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mag_b <= mag_b >> 1;
        cnt   <= cnt + CW'(1);
      end
      if (finish) p <= neg ? (~acc_lo + DATAWIDTH'(1)) : acc_lo;
    end
  end

`ifdef SEQ_MUL_OVF_EN
  localparam logic [2*DATAWIDTH-1:0] HALF = {{DATAWIDTH{1'b0}}, 1'b1, {(DATAWIDTH-1){1'b0}}};
  logic ovf_q;

  // Positive results may reach 2^(DW-1)-1, negative results may reach -2^(DW-1).
  always_ff @(posedge clk) begin
    if (rst)         ovf_q <= 1'b0;
    else if (finish) ovf_q <= neg ? (acc > HALF) : (acc >= HALF);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_mul.sv
//------------------------------------------------------------------------------
// tb_seq_mul : scoreboard bench for seq_mul at DATAWIDTH=32.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_mul;

  localparam int DW = 32;
`ifdef SEQ_MUL_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          busy, done, ovf;
  logic [DW-1:0] p;

  seq_mul #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] p;
    logic          ovf;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;
  bit   b2b = 1'b0;
  int   last_done = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Issued from a negedge; the DUT samples at the following posedge.
  task automatic issue(input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                       input logic [DW-1:0] ep, input logic eo, input bit push);
    int guard = 0;
    exp_t x;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("busy_timeout", 64'(busy), 64'd0);
    a = ta;
    b = tb;
    start = 1'b1;
    if (push) begin
      x.p = ep;
      x.ovf = eo & OVF_ON;
      x.cyc = cyc + 34;
      q.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((q.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: p=0x%0h expected no done (cycle %0d)", p, cyc);
      end else begin
        e = q.pop_front();
        chk("p", 64'(p), 64'(e.p));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
        if (b2b && last_done >= 0) chk("spacing", 64'(cyc - last_done), 64'd34);
        last_done = cyc;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]       ra, rb;
    logic signed [63:0]  full;

    repeat (10) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_p", 64'(p), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);

    issue(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("busy_after_start", 64'(busy), 64'd1);
    drain();

    issue(32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    issue(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b1);
    issue(32'h7FFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1);
    drain();

    // Start re-asserted mid-operation with new operands must be ignored.
    issue(32'd3, 32'd5, 32'd15, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    a = 32'd100;
    b = 32'd100;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    drain();

    // Reset mid-operation aborts without a done pulse.
    issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_p", 64'(p), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    repeat (40) @(negedge clk);
    issue(32'd2, 32'd9, 32'd18, 1'b0, 1'b1);
    drain();

    b2b = 1'b1;
    last_done = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      full = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      issue(ra, rb, full[DW-1:0],
            (full > 64'sh0000_0000_7FFF_FFFF) || (full < -64'sh0000_0000_8000_0000), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
